// File: rtl/share_1_a4_inv_serial_pkg.sv
// Shared PRINCE TI definitions for the serial inverse-A4 block:
// FSM state encoding, default word size and counter sizing helper.
package share_1_a4_inv_serial_pkg;

    localparam int unsigned NIBBLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble counter width: clog2(n), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/share_1_a4_inv.sv
// Combinational inverse of the first-share A4 affine map on one nibble.
module share_1_a4_inv (
    input  logic [3:0] y,
    output logic [3:0] x
);

    always_comb begin
        x[3] = y[2];
        x[2] = y[3] ^ y[1];
        x[1] = 1'b1 ^ y[2] ^ y[1] ^ y[0];
        x[0] = y[0];
    end

endmodule

// File: rtl/share_1_a4_inv_serial.sv
// Nibble-serial inverse-A4 mapper: loads a word, rotates it through a single
// share_1_a4_inv instance one nibble per cycle, then holds the result.
module share_1_a4_inv_serial
    import share_1_a4_inv_serial_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    input  logic                   abort,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = cnt_width(NIBBLES);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    data;
    logic [W-1:0]    data_shifted;
    logic [3:0]      nib_mapped;
    logic            cnt_last;

    share_1_a4_inv u_inv (
        .y (data[3:0]),
        .x (nib_mapped)
    );

    // Mapped low nibble re-enters at the top, so after NIBBLES steps every
    // nibble is back in its original lane.
    generate
        if (NIBBLES == 1) begin : g_single
            assign data_shifted = nib_mapped;
        end else begin : g_multi
            assign data_shifted = {nib_mapped, data[W-1:4]};
        end
    endgenerate

    assign cnt_last = (cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  state_next = RUN;
                RUN:     if (cnt_last)  state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default:                state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // Counter saturates on the last step so it never wraps inside a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data <= in_data;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    data <= data_shifted;
                    if (!cnt_last) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = data;

endmodule

// File: tb/tb_share_1_a4_inv_serial.sv
// Directed self-checking bench for share_1_a4_inv_serial with a
// transaction-level reference model checked every cycle.
module tb_share_1_a4_inv_serial;

    localparam int unsigned NIB = 16;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         abort;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    share_1_a4_inv_serial #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .abort     (abort),
        .busy      (busy)
    );

    // y -> x inverse table, indexed by y.
    logic [3:0] inv_tbl [16] = '{4'h2, 4'h1, 4'h4, 4'h7, 4'h8, 4'hB, 4'hE, 4'hD,
                                 4'h6, 4'h5, 4'h0, 4'h3, 4'hC, 4'hF, 4'hA, 4'h9};

    function automatic logic [W-1:0] inv_word(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < NIB; i++) r[4*i +: 4] = inv_tbl[v[4*i +: 4]];
        return r;
    endfunction

    // Forward A4 obtained by searching the inverse table.
    function automatic logic [W-1:0] fwd_word(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NIB; i++)
            for (int y = 0; y < 16; y++)
                if (inv_tbl[y] == v[4*i +: 4]) r[4*i +: 4] = 4'(y);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: idle / NIB cycles of work / result held until taken.
    bit           m_idle;
    int           m_rem;
    logic [W-1:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_rem  <= 0;
            m_exp  <= '0;
        end else if (abort) begin
            m_idle <= 1'b1;
            m_rem  <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_rem  <= NIB;
                m_exp  <= inv_word(in_data);
            end
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
        end else if (out_ready) begin
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_in_ready", W'(in_ready), W'(m_idle));
            check("model_busy", W'(busy), W'(!m_idle && m_rem != 0));
            check("model_out_valid", W'(out_valid), W'(!m_idle && m_rem == 0));
            if (!m_idle && m_rem == 0) check("model_out_data", out_data, m_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called one step after the accept edge; returns cycle index of out_valid.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: got timeout expected out_valid");
        end
    endtask

    task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] exp, input int hold);
        int           cyc;
        logic [W-1:0] got;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        step();
        in_valid  = 1'b0;
        in_data   = '0;
        wait_valid(cyc);
        check("latency", W'(cyc), W'(17));
        got = out_data;
        check("result", got, exp);
        check("fwd_recover", fwd_word(got), d);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_data", out_data, exp);
            check("hold_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        step();
        check("post_out_valid", W'(out_valid), W'(0));
        check("post_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        abort     = 1'b0;
        repeat (3) step();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", W'(in_ready), W'(1));
        check("rel_out_data", out_data, '0);

        xfer(64'hAAAAAAAAAAAAAAAA, 64'h0000000000000000, 0);
        xfer(64'h0123456789ABCDEF, 64'h21478BED6503CFA9, 0);
        xfer(64'hFEDCBA9876543210, 64'h9AFC3056DEB87412, 5);

        // Abort at nibble count 7.
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        check("abort_busy_before", W'(busy), W'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_busy", W'(busy), W'(0));
        check("abort_out_valid", W'(out_valid), W'(0));
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort_no_valid", W'(out_valid), W'(0));
        end
        xfer(64'h0000000000000000, 64'h2222222222222222, 0);

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5555555555555555;
        step();
        in_valid = 1'b0;
        wait_valid(cyc);
        check("rstdone_valid", W'(out_valid), W'(1));
        #4;
        rst_n = 1'b0;
        #1;
        check("rstdone_async_valid", W'(out_valid), W'(0));
        check("rstdone_async_data", out_data, '0);
        step();
        rst_n = 1'b1;
        check("rstdone_in_ready", W'(in_ready), W'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstdone_no_valid", W'(out_valid), W'(0));
        end

        // in_valid held high across a whole transfer.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h3C3C3C3C3C3C3C3C;
        step();
        in_data = 64'h00000000FFFFFFFF;
        wait_valid(cyc);
        check("held_latency_a", W'(cyc), W'(17));
        check("held_result_a", out_data, 64'h7C7C7C7C7C7C7C7C);
        step();
        check("held_gap_in_ready", W'(in_ready), W'(1));
        check("held_gap_busy", W'(busy), W'(0));
        step();
        in_valid = 1'b0;
        check("held_b_busy", W'(busy), W'(1));
        wait_valid(cyc);
        check("held_latency_b", W'(cyc), W'(17));
        check("held_result_b", out_data, 64'h2222222299999999);
        step();
        check("held_end_valid", W'(out_valid), W'(0));
        out_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
